// File: rtl/pinball_pkg.sv
// Shared encodings and defaults for the pinball table game sequencer.
// State codes are exported on the state port, so their values are fixed.
package pinball_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READY  = 3'd1;
  localparam logic [2:0] ST_CHARGE = 3'd2;
  localparam logic [2:0] ST_FIRE   = 3'd3;
  localparam logic [2:0] ST_PLAY   = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
  localparam logic [2:0] ST_OVER   = 3'd6;

  localparam int DEF_DB_DEPTH = 5;
  localparam int DEF_BALLS    = 3;
  localparam int DEF_POINTS   = 10;
  localparam int DEF_SCORE_W  = 16;
  localparam int DEF_CHARGE_W = 8;
  localparam int DEF_BLINK_W  = 24;

  // Bit positions of the conditioned switch inputs.
  localparam int IN_START  = 0;
  localparam int IN_LAUNCH = 1;
  localparam int IN_TARGET = 2;
  localparam int IN_DRAIN  = 3;
  localparam int NUM_IN    = 4;

  // Attract states: no ball in play, status LED blinks.
  function automatic logic is_attract(state_t s);
    return (s == ST_IDLE) || (s == ST_OVER);
  endfunction

endpackage

// File: rtl/pinball_input_cond.sv
// Switch conditioner: shift-register debounce plus a registered rising-edge pulse.
module pinball_input_cond
  import pinball_pkg::*;
#(
  parameter int DB_DEPTH = DEF_DB_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  logic [DB_DEPTH-1:0] shift_q, shift_d;
  logic                lvl_dly_q, lvl_dly_d;
  logic                pulse_q, pulse_d;

  // Level needs DB_DEPTH consecutive high samples.
  assign level = &shift_q;
  assign pulse = pulse_q;

  always_comb begin
    shift_d   = DB_DEPTH'({shift_q, raw});
    lvl_dly_d = level;
    pulse_d   = level & ~lvl_dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      lvl_dly_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      lvl_dly_q <= lvl_dly_d;
      pulse_q   <= pulse_d;
    end
  end

endmodule

// File: rtl/pinball_game_ctrl.sv
// Pinball game sequencer: conditions the table switches, runs the game FSM,
// keeps score and balls, fires the plunger and drives the status LED.
module pinball_game_ctrl
  import pinball_pkg::*;
#(
  parameter int DB_DEPTH = DEF_DB_DEPTH,
  parameter int BALLS    = DEF_BALLS,
  parameter int POINTS   = DEF_POINTS,
  parameter int SCORE_W  = DEF_SCORE_W,
  parameter int CHARGE_W = DEF_CHARGE_W,
  parameter int BLINK_W  = DEF_BLINK_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_btn,
  input  logic                launch_btn,
  input  logic                target_sw,
  input  logic                drain_sw,
  output logic [2:0]          state,
  output logic [SCORE_W-1:0]  score,
  output logic [2:0]          balls_left,
  output logic                launch_fire,
  output logic [CHARGE_W-1:0] launch_power,
  output logic                status_led
);

  logic [NUM_IN-1:0] raw_in, lvl, pls;
  logic              cond_unused;

  assign raw_in = {drain_sw, target_sw, launch_btn, start_btn};

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cond
      pinball_input_cond #(.DB_DEPTH(DB_DEPTH)) u_cond (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw_in[gi]),
        .level (lvl[gi]),
        .pulse (pls[gi])
      );
    end
  endgenerate

  // Only the launch level and the other three pulses drive the game.
  assign cond_unused = ^{lvl[IN_START], lvl[IN_TARGET], lvl[IN_DRAIN], pls[IN_LAUNCH]};

  state_t              state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [2:0]          balls_q, balls_d;
  logic [CHARGE_W-1:0] charge_q, charge_d;
  logic                fire_q, fire_d;
  logic [CHARGE_W-1:0] power_q, power_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic                led_q, led_d;

  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;
  logic [CHARGE_W-1:0] charge_inc;

  assign score_sum  = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);
  assign score_sat  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign charge_inc = (&charge_q) ? charge_q : charge_q + CHARGE_W'(1);

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    balls_d  = balls_q;
    charge_d = charge_q;
    fire_d   = 1'b0;
    power_d  = power_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (pls[IN_START]) begin
          state_d = ST_READY;
          balls_d = 3'(BALLS);
          score_d = '0;
        end
      end
      ST_READY: begin
        if (lvl[IN_LAUNCH]) begin
          state_d  = ST_CHARGE;
          charge_d = '0;
        end
      end
      ST_CHARGE: begin
        charge_d = charge_inc;
        // Strobe and power are registered on the way into FIRE so they
        // are visible for exactly the FIRE cycle.
        if (!lvl[IN_LAUNCH]) begin
          state_d = ST_FIRE;
          fire_d  = 1'b1;
          power_d = charge_inc;
        end
      end
      ST_FIRE: state_d = ST_PLAY;
      ST_PLAY: begin
        if (pls[IN_TARGET]) score_d = score_sat;
        if (pls[IN_DRAIN])  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        balls_d = (balls_q != 3'd0) ? balls_q - 3'd1 : 3'd0;
        state_d = (balls_d == 3'd0) ? ST_OVER : ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase

    blink_d = blink_q;
    if (state_d == ST_READY && state_q != ST_READY) begin
      blink_d = '0;
    end else if (is_attract(state_q)) begin
      blink_d = blink_q + BLINK_W'(1);
    end
    led_d = is_attract(state_d) ? blink_d[BLINK_W-1] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      score_q  <= '0;
      balls_q  <= '0;
      charge_q <= '0;
      fire_q   <= 1'b0;
      power_q  <= '0;
      blink_q  <= '0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      balls_q  <= balls_d;
      charge_q <= charge_d;
      fire_q   <= fire_d;
      power_q  <= power_d;
      blink_q  <= blink_d;
      led_q    <= led_d;
    end
  end

  assign state        = state_q;
  assign score        = score_q;
  assign balls_left   = balls_q;
  assign launch_fire  = fire_q;
  assign launch_power = power_q;
  assign status_led   = led_q;

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Scoreboard bench for pinball_game_ctrl: game-rule model pushes expected
// state/score/fire events, a negedge monitor pops and compares them.
module tb_pinball_game_ctrl;

  localparam int DB  = 5;
  localparam int NB  = 3;
  localparam int PTS = 10;
  localparam int SW  = 16;
  localparam int CW  = 8;
  localparam int BW  = 4;
  localparam int SMAX = (1 << SW) - 1;
  localparam int CMAX = (1 << CW) - 1;

  localparam int S_IDLE = 0, S_READY = 1, S_CHARGE = 2, S_FIRE = 3;
  localparam int S_PLAY = 4, S_DRAIN = 5, S_OVER = 6;

  localparam logic [3:0] M_START = 4'b0001, M_LAUNCH = 4'b0010;
  localparam logic [3:0] M_TARGET = 4'b0100, M_DRAIN = 4'b1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    btn = 4'b0;
  logic [2:0]    state;
  logic [SW-1:0] score;
  logic [2:0]    balls_left;
  logic          launch_fire;
  logic [CW-1:0] launch_power;
  logic          status_led;

  always #5 clk = ~clk;

  pinball_game_ctrl #(
    .DB_DEPTH(DB), .BALLS(NB), .POINTS(PTS),
    .SCORE_W(SW), .CHARGE_W(CW), .BLINK_W(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .start_btn(btn[0]), .launch_btn(btn[1]), .target_sw(btn[2]), .drain_sw(btn[3]),
    .state(state), .score(score), .balls_left(balls_left),
    .launch_fire(launch_fire), .launch_power(launch_power), .status_led(status_led)
  );

  typedef struct { int st; int balls; int score; } st_exp_t;
  st_exp_t st_sb[$];
  int      score_sb[$];
  int      fire_sb[$];

  int compared   = 0;
  int mismatched = 0;

  int m_state = S_IDLE, m_balls = 0, m_score = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit attract(input int s);
    return (s == S_IDLE) || (s == S_OVER);
  endfunction

  // ---------------- game-rule reference model ----------------
  task automatic goto_st(input int s);
    if (s != m_state) begin
      st_sb.push_back('{st: s, balls: m_balls, score: m_score});
      m_state = s;
    end
  endtask

  task automatic set_score(input int v);
    if (v != m_score) score_sb.push_back(v);
    m_score = v;
  endtask

  task automatic press(input logic [3:0] m, input int len);
    @(negedge clk);
    btn = btn | m;
    repeat (len) @(negedge clk);
    btn = btn & ~m;
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"wait_", nm}, state, s);
  endtask

  task automatic start_game(input int len);
    m_balls = NB;
    set_score(0);
    goto_st(S_READY);
    press(M_START, len);
    wait_state(S_READY, 20, "start");
  endtask

  // Held N edges: launch level seen from edge DB+1, released level seen at
  // edge N+2, so CHARGE spans N-DB+1 cycles.
  task automatic launch_shot(input int n);
    int p = n - DB + 1;
    if (p > CMAX) p = CMAX;
    goto_st(S_CHARGE);
    goto_st(S_FIRE);
    fire_sb.push_back(p);
    goto_st(S_PLAY);
    press(M_LAUNCH, n);
    wait_state(S_PLAY, 20, "play");
  endtask

  task automatic hit(input int len, input int gap);
    set_score((m_score + PTS > SMAX) ? SMAX : m_score + PTS);
    press(M_TARGET, len);
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain_ball(input bit with_target);
    if (with_target) set_score((m_score + PTS > SMAX) ? SMAX : m_score + PTS);
    goto_st(S_DRAIN);
    m_balls--;
    goto_st(m_balls == 0 ? S_OVER : S_READY);
    press(with_target ? (M_DRAIN | M_TARGET) : M_DRAIN, $urandom_range(5, 9));
    wait_state(m_state, 20, "drain");
  endtask

  task automatic play_ball();
    int r = $urandom_range(0, 3);
    if (r == 1) press(M_TARGET, $urandom_range(5, 8));
    if (r == 2) press(M_DRAIN, $urandom_range(5, 8));
    if (r == 3) press(M_START, $urandom_range(5, 8));
    repeat (2) @(negedge clk);
    launch_shot($urandom_range(5, 300));
    for (int h = 0; h < int'($urandom_range(0, 4)); h++) begin
      if ($urandom_range(0, 2) == 0) press(M_TARGET, $urandom_range(1, DB - 1));
      hit($urandom_range(5, 9), $urandom_range(0, 3));
    end
    if ($urandom_range(0, 2) == 0) press(M_START, $urandom_range(5, 8));
    drain_ball($urandom_range(0, 3) == 0);
  endtask

  // ---------------- monitor ----------------
  bit mon_en = 1'b0;
  int prev_state = 0, prev_score = 0, blink_k = 0, hold_power = 0, cur_balls = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      st_exp_t e;
      int p;
      if (rst) begin
        hold_power = 0;
        cur_balls  = 0;
      end
      if (int'(state) != prev_state) begin
        if (st_sb.size() == 0) check("state_unexpected", state, prev_state);
        else begin
          e = st_sb.pop_front();
          check("state", state, e.st);
          check("state_balls", balls_left, e.balls);
          check("state_score", score, e.score);
          cur_balls = e.balls;
        end
      end
      check("balls_hold", balls_left, cur_balls);
      if (int'(score) != prev_score) begin
        if (score_sb.size() == 0) check("score_unexpected", score, prev_score);
        else check("score", score, score_sb.pop_front());
      end
      if (launch_fire) begin
        if (fire_sb.size() == 0) check("fire_unexpected", launch_fire, 0);
        else begin
          p = fire_sb.pop_front();
          check("fire_power", launch_power, p);
          hold_power = p;
        end
      end else begin
        check("power_hold", launch_power, hold_power);
      end
      if (rst) blink_k = 0;
      else if (attract(state)) blink_k = attract(prev_state) ? blink_k + 1 : 0;
      check("status_led", status_led, attract(state) ? ((blink_k >> (BW - 1)) & 1) : 1);
      prev_state = state;
      prev_score = score;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_state", state, S_IDLE);
    check("rst_score", score, 0);
    check("rst_balls", balls_left, 0);
    check("rst_fire", launch_fire, 0);
    check("rst_power", launch_power, 0);
    check("rst_led", status_led, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    press(M_START, 3);
    repeat (10) @(negedge clk);
    check("glitch_state", state, S_IDLE);

    start_game(8);
    check("ready_balls", balls_left, NB);
    check("ready_led", status_led, 1);

    launch_shot(20);
    check("power_20", launch_power, 16);

    for (int i = 0; i < 4; i++) hit($urandom_range(5, 9), $urandom_range(0, 3));
    repeat (3) @(negedge clk);
    check("score_40", score, 40);

    drain_ball(1'b1);
    check("aligned_score", score, 50);
    check("aligned_balls", balls_left, 2);

    launch_shot(400);
    check("power_sat", launch_power, CMAX);
    drain_ball(1'b0);
    launch_shot($urandom_range(5, 60));
    drain_ball(1'b0);
    check("over_state", state, S_OVER);
    check("over_balls", balls_left, 0);
    repeat (40) @(negedge clk);

    start_game(6);
    check("restart_score", score, 0);
    check("restart_balls", balls_left, NB);

    for (int b = 0; b < 12; b++) begin
      if (m_state == S_OVER) start_game($urandom_range(5, 10));
      play_ball();
    end

    // Score saturation with back-to-back minimum-length target presses.
    if (m_state == S_OVER) start_game(6);
    launch_shot(30);
    for (int i = 0; i < (SMAX / PTS) + 3; i++) hit(DB, 0);
    repeat (3) @(negedge clk);
    check("score_sat", score, SMAX);
    drain_ball(1'b0);
    if (m_state == S_OVER) start_game(6);

    // Asynchronous reset in the middle of a charge.
    goto_st(S_CHARGE);
    @(negedge clk);
    btn[1] = 1'b1;
    wait_state(S_CHARGE, 20, "charge");
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    m_balls = 0;
    set_score(0);
    goto_st(S_IDLE);
    #1;
    check("arst_state", state, S_IDLE);
    check("arst_score", score, 0);
    check("arst_balls", balls_left, 0);
    check("arst_fire", launch_fire, 0);
    check("arst_power", launch_power, 0);
    check("arst_led", status_led, 0);
    btn[1] = 1'b0;
    btn[0] = 1'b1;
    m_balls = NB;
    goto_st(S_READY);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    btn[0] = 1'b0;
    wait_state(S_READY, 20, "held_start");
    check("held_start_balls", balls_left, NB);

    repeat (10) @(negedge clk);
    check("sb_state_left", st_sb.size(), 0);
    check("sb_score_left", score_sb.size(), 0);
    check("sb_fire_left", fire_sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pinball_game_ctrl.md
Name: pinball_game_ctrl

Overview:
- Top-level game sequencer for the pinball table.
- Conditions the raw start, launch, target and drain switch inputs (debounce plus edge pulse).
- Runs the game state machine: idle → ball ready → plunger charge → fire → play → drain → game over.
- Tracks score and balls left, generates the plunger fire pulse with charge strength, and drives the status LED.

Parameters:
- DB_DEPTH, 5, debounce shift length; input must be sampled high on DB_DEPTH consecutive edges.
- BALLS, 3, balls per game (1..7).
- POINTS, 10, score added per target hit.
- SCORE_W, 16, score width.
- CHARGE_W, 8, plunger charge counter width.
- BLINK_W, 24, blink divider width; status LED blinks at MSB rate.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start_btn  in  1  raw start button
- launch_btn  in  1  raw plunger button, held to charge
- target_sw  in  1  raw target switch
- drain_sw  in  1  raw drain sensor, high when ball is in drain
- state  out  3  current FSM state (package encoding)
- score  out  SCORE_W  current score
- balls_left  out  3  balls remaining
- launch_fire  out  1  one-cycle plunger fire strobe
- launch_power  out  CHARGE_W  charge latched at fire, held until next fire
- status_led  out  1  game status LED

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On assertion, all registers clear immediately:
  - state=IDLE; score=0; balls_left=0; launch_fire=0; launch_power=0.
  - Charge counter=0; blink counter=0; status_led=0.
  - All conditioner shift and delay registers=0.
- Reset mid-game aborts the game with no fire strobe.
- Conditioning, per input:
  - Shift register samples raw on each clk edge.
  - Debounced level = AND of all DB_DEPTH bits.
  - Pulse = registered (level & ~level_d).
  - Raw sampled high on edges 1..DB_DEPTH → level high after edge DB_DEPTH → pulse high for exactly the cycle after edge DB_DEPTH+1.
  - Glitches shorter than DB_DEPTH samples → no level, no pulse.
  - Input held high across reset release → one pulse.
- FSM (one transition per edge):
  - IDLE: start_p → READY; balls_left=BALLS, score=0.
  - READY: launch level high → CHARGE; charge=0.
  - CHARGE: charge+1 per cycle, saturating at 2^CHARGE_W-1. Launch level low → FIRE.
  - FIRE: launch_fire=1 this cycle only; launch_power=charge. Next state PLAY.
  - PLAY: target_p → score += POINTS, saturating at 2^SCORE_W-1. drain_p → DRAIN.
  - DRAIN (one cycle): balls_left-1. Result 0 → OVER, else READY.
  - OVER: start_p → READY; balls_left=BALLS, score=0.
- Ignored events:
  - start_p outside IDLE/OVER.
  - target_p outside PLAY.
  - drain_p outside PLAY.
- Simultaneous target_p and drain_p in PLAY: score is added AND the DRAIN transition is taken.
- status_led:
  - IDLE and OVER: blink counter MSB. Counter free-runs there and clears on entry to READY.
  - READY, CHARGE, FIRE, PLAY, DRAIN: 1.
- Outputs are registered, except state, which is the state register itself.

Decomposition:
- Package pinball_pkg:
  - 3-bit state encoding: IDLE=0, READY=1, CHARGE=2, FIRE=3, PLAY=4, DRAIN=5, OVER=6.
  - Default parameter constants.
- Sub-module pinball_input_cond (param DB_DEPTH; ports clk, rst, raw, level, pulse), instantiated 4×.
- FSM, score/balls/charge counters and blink divider stay in the top.

Test Plan (DB_DEPTH=5, BALLS=3, POINTS=10, CHARGE_W=8, BLINK_W=4):
- Reset, then start_btn high 3 cycles → no pulse, state stays 0. Start held 8 cycles → state 1 (READY), balls_left=3, score=0, status_led=1.
- In READY, launch held 20 cycles then released → launch_fire high exactly one cycle; launch_power = cycles spent in CHARGE (bench checks exact count); state 4 (PLAY).
- Launch held 400 cycles → launch_power=255 (saturates), no wrap.
- In PLAY, 4 clean target presses → score=40. Target and drain edges aligned in the same cycle → score=50, balls_left=2, state 1.
- Three drains → balls_left 3→2→1→0, final state 6 (OVER); status_led toggles every 8 cycles. Start → READY, score=0, balls_left=3.
- rst asserted in CHARGE between clock edges → outputs 0 immediately, state 0, no launch_fire. Score preset near 65535 via repeated hits → saturates at 65535.
